sha256_const_sequencer: RTL and testbench
=========================================

Name: sha256_const_sequencer

Overview:
- Sequences the two SHA-256 constant ROMs (`block_rom` instances) for one 512-bit message block:
  - the initial hash ROM: 8 x 32-bit words, H0..H7;
  - the round-constant ROM: 64 x 32-bit words, K0..K63.
- Presents the words as one valid/ready stream to the compression datapath: optional H0..H7 load beats first, then K0..K63 round beats.
- Hides the ROMs' 1-cycle read latency and holds data stable under backpressure.

Parameters:
- NUM_H, 8, number of initial hash words
- NUM_ROUNDS, 64, number of round constants
- W, 32, word width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  request to process one block
- first_block  in  1  sampled with start; 1 = emit H0..H7 before rounds, 0 = rounds only (chained block)
- start_ready  out  1  high only in IDLE
- h_rom_addr  out  3  address to hash-value ROM, combinational from pointer-next
- h_rom_data  in  W  hash ROM read data, valid 1 cycle after address
- k_rom_addr  out  6  address to K ROM, combinational from pointer-next
- k_rom_data  in  W  K ROM read data, valid 1 cycle after address
- out_valid  out  1  out_data/out_idx/out_is_k valid
- out_ready  in  1  downstream accepts beat
- out_data  out  W  H word or K constant
- out_idx  out  6  word index (0..7 for H, 0..63 for K)
- out_is_k  out  1  0 = H beat, 1 = K beat
- done  out  1  1-cycle pulse after last K beat transfers

Behaviour:
- Interface decision: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state IDLE, out_valid=0, done=0, start_ready=1, pointer=0, out_is_k=0. Address outputs are 0 in IDLE.
- Reset mid-operation: abandon the block; no further beats; no done pulse.
- Transfer: out_valid && out_ready on a rising edge.
- States: IDLE -> PRIME -> LOAD_H -> ROUNDS -> DONE -> IDLE.
- IDLE:
  - start_ready=1.
  - On start: latch first_block, go to PRIME.
  - Address outputs present index 0 so the ROM read issues on the accept edge.
- PRIME:
  - One cycle; out_valid=0 while the ROM read completes.
  - Next state is LOAD_H if first_block, else ROUNDS.
  - First out_valid is asserted 2 cycles after the accepting edge.
- Pointer rule:
  - An internal pointer holds the index of the word currently on out_data.
  - ROM address outputs are driven combinationally with the pointer's next value. The ROM therefore always samples the address whose data appears after the edge.
  - Under stall (out_valid && !out_ready) the pointer and address hold. The ROM re-reads, so out_data/out_idx/out_is_k stay stable.
  - out_data = out_is_k ? k_rom_data : h_rom_data.
- LOAD_H:
  - Emits H0..H7 with idx 0..7, out_is_k=0.
  - On transfer at idx 7: the pointer goes to 0, out_is_k goes to 1, state goes to ROUNDS. The K ROM is addressed at 0 on that same edge, so there is no bubble.
- ROUNDS:
  - Emits K0..K63, out_is_k=1.
  - On transfer at idx 63: go to DONE; out_valid drops next cycle.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - start is ignored in DONE (start_ready=0).
- Throughput: with out_ready held high, one beat per cycle.
  - first_block=1: 72 contiguous beats.
  - first_block=0: 64 contiguous beats.
- start while busy: ignored; start_ready=0 outside IDLE.
- Indices never wrap mid-phase. Pointer widths are $clog2 of each ROM length.

Decomposition:
- sha256_pkg:
  - NUM_H, NUM_ROUNDS, WORD_W constants;
  - state enum (IDLE, PRIME, LOAD_H, ROUNDS, DONE);
  - index typedefs h_idx_t (3b) and k_idx_t (6b).
- No sub-module. The two `block_rom` instances live in the enclosing top, initialised with hash_values.memh and k_constants.memh; the sequencer only drives addresses.
- Bench: instantiates both ROMs alongside the DUT.

Test Plan:
- Reset, then start=1, first_block=1, out_ready=1 -> out_valid rises 2 cycles after accept; beats 0-7 = 6a09e667..5be0cd19 (out_is_k=0), then 64 beats with idx 0 = 428a2f98 and idx 63 = c67178f2; done 1 cycle after last beat.
- start with first_block=0, out_ready=1 -> first beat is K0=428a2f98, idx 0, out_is_k=1; exactly 64 beats; done pulse.
- Random out_ready (50%) across full 72-beat run -> during each stall cycle data/idx held stable; transfers exactly 72, in order; H7 to K0 boundary has no skipped or duplicated word.
- Stall held 5 cycles at H7 (idx 7), then release -> H7=5be0cd19 repeated stably for 5 cycles; next transferred beat is K0=428a2f98.
- Assert start during ROUNDS and in the DONE cycle -> ignored; start_ready=0; after return to IDLE a new start is accepted normally.
- rst asserted at round 30 -> next cycle out_valid=0, start_ready=1, no done pulse; a following start replays from H0.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared constants, index types and FSM state encoding for the SHA-256
// constant sequencer.
package sha256_pkg;

  localparam int NUM_H      = 8;
  localparam int NUM_ROUNDS = 64;
  localparam int WORD_W     = 32;

  localparam int H_IDX_W = $clog2(NUM_H);
  localparam int K_IDX_W = $clog2(NUM_ROUNDS);

  typedef logic [H_IDX_W-1:0] h_idx_t;
  typedef logic [K_IDX_W-1:0] k_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    LOAD_H,
    ROUNDS,
    DONE
  } state_t;

  // One beat of the output stream, as seen by a consumer.
  typedef struct packed {
    logic [WORD_W-1:0] data;
    k_idx_t            idx;
    logic              is_k;
  } beat_t;

endpackage

// File: rtl/sha256_const_sequencer_if.sv
// Valid/ready word stream from the constant sequencer to the compression
// datapath. The sequencer is the master; the datapath is the slave.
interface sha256_const_sequencer_if #(
  parameter int W     = sha256_pkg::WORD_W,
  parameter int IDX_W = sha256_pkg::K_IDX_W
);

  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_is_k;

  modport master (
    output out_valid,
    output out_data,
    output out_idx,
    output out_is_k,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_idx,
    input  out_is_k,
    output out_ready
  );

endinterface

// File: rtl/sha256_const_sequencer.sv
// Walks the hash-value ROM (optional) and the round-constant ROM for one
// message block and presents the words as a single valid/ready stream.
// ROM addresses are driven from the pointers' next values so the synchronous
// ROMs always hold the word that belongs on out_data after each edge; this
// hides the read latency and keeps data stable while the consumer stalls.
module sha256_const_sequencer #(
  parameter int NUM_H      = sha256_pkg::NUM_H,
  parameter int NUM_ROUNDS = sha256_pkg::NUM_ROUNDS,
  parameter int W          = sha256_pkg::WORD_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          first_block,
  output logic                          start_ready,
  output logic [$clog2(NUM_H)-1:0]      h_rom_addr,
  input  logic [W-1:0]                  h_rom_data,
  output logic [$clog2(NUM_ROUNDS)-1:0] k_rom_addr,
  input  logic [W-1:0]                  k_rom_data,
  output logic                          done,
  sha256_const_sequencer_if.master      stream
);

  import sha256_pkg::*;

  localparam int HW = $clog2(NUM_H);
  localparam int KW = $clog2(NUM_ROUNDS);

  localparam logic [HW-1:0] H_LAST = HW'(NUM_H - 1);
  localparam logic [KW-1:0] K_LAST = KW'(NUM_ROUNDS - 1);

  state_t          state, state_nxt;
  logic [HW-1:0]   h_ptr, h_nxt;
  logic [KW-1:0]   k_ptr, k_nxt;
  logic            is_k, is_k_nxt;
  logic            first_q;
  logic            xfer;

  // Beats are only offered while emitting H or K words.
  assign stream.out_valid = (state == LOAD_H) || (state == ROUNDS);
  assign xfer             = stream.out_valid && stream.out_ready;

  // The ROMs sample the pointer's next value, so their data lines up with
  // the pointer on the following cycle.
  assign h_rom_addr = h_nxt;
  assign k_rom_addr = k_nxt;

  assign stream.out_is_k = is_k;
  assign stream.out_data = is_k ? k_rom_data : h_rom_data;
  assign stream.out_idx  = is_k ? k_ptr : KW'(h_ptr);

  // State, pointers and phase flag; first_block is captured on the accepted start.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      state   <= IDLE;
      h_ptr   <= '0;
      k_ptr   <= '0;
      is_k    <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state <= state_nxt;
      h_ptr <= h_nxt;
      k_ptr <= k_nxt;
      is_k  <= is_k_nxt;
      if (state == IDLE && start) begin
        first_q <= first_block;
      end
    end
  end

  // Next-state, pointer advance and control outputs.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_nxt   = state;
    h_nxt       = h_ptr;
    k_nxt       = k_ptr;
    is_k_nxt    = is_k;
    start_ready = 1'b0;
    done        = 1'b0;

    case (state)
      IDLE: begin
        start_ready = 1'b1;
        h_nxt       = '0;
        k_nxt       = '0;
        if (start) begin
          state_nxt = PRIME;
          is_k_nxt  = !first_block;
        end
      end

      // Both ROMs were addressed at 0 on the accept edge; wait for the read.
      PRIME: begin
        state_nxt = first_q ? LOAD_H : ROUNDS;
      end

      LOAD_H: begin
        if (xfer) begin
          if (h_ptr == H_LAST) begin
            // K ROM is addressed at 0 on this same edge: no bubble.
            h_nxt     = '0;
            k_nxt     = '0;
            is_k_nxt  = 1'b1;
            state_nxt = ROUNDS;
          end else begin
            h_nxt = h_ptr + HW'(1);
          end
        end
      end

      ROUNDS: begin
        if (xfer) begin
          if (k_ptr == K_LAST) begin
            k_nxt     = '0;
            state_nxt = DONE;
          end else begin
            k_nxt = k_ptr + KW'(1);
          end
        end
      end

      DONE: begin
        done      = 1'b1;
        h_nxt     = '0;
        k_nxt     = '0;
        is_k_nxt  = 1'b0;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sha256_const_sequencer.sv
// Bench for sha256_const_sequencer: models both constant ROMs, pushes the
// expected beat sequence into a scoreboard queue when each block is started,
// and a negedge monitor pops and compares every transferred beat.
module tb_sha256_const_sequencer;

  import sha256_pkg::*;

  localparam logic [31:0] H_TAB [NUM_H] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K_TAB [NUM_ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        first_block;
  logic        start_ready;
  logic        done;
  h_idx_t      h_rom_addr;
  k_idx_t      k_rom_addr;
  logic [31:0] h_rom_data;
  logic [31:0] k_rom_data;

  sha256_const_sequencer_if stream ();

  sha256_const_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .first_block (first_block),
    .start_ready (start_ready),
    .h_rom_addr  (h_rom_addr),
    .h_rom_data  (h_rom_data),
    .k_rom_addr  (k_rom_addr),
    .k_rom_data  (k_rom_data),
    .done        (done),
    .stream      (stream)
  );

  always #5 clk = ~clk;

  // Synchronous ROMs with one cycle of read latency.
  always @(posedge clk) begin
    h_rom_data <= H_TAB[h_rom_addr];
    k_rom_data <= K_TAB[k_rom_addr];
  end

  int    total = 0;
  int    bad   = 0;
  beat_t exp_q [$];

  int    xfer_cnt     = 0;
  int    done_cnt     = 0;
  int    h7_stall_cnt = 0;
  int    ready_mode   = 0;  // 0: always ready, 1: random, 2: stall 5 cycles at H7
  int    stall_left   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares transferred beats against the scoreboard, checks that
  // stalled beats hold still and that done follows the last K beat by one cycle.
  initial begin : monitor
    logic  pend_done;
    logic  held_v;
    beat_t held;
    beat_t cur;
    beat_t e;
    pend_done = 1'b0;
    held_v    = 1'b0;
    held      = '0;
    forever begin
      @(negedge clk);
      cur.data = stream.out_data;
      cur.idx  = stream.out_idx;
      cur.is_k = stream.out_is_k;
      if (rst) begin
        pend_done = 1'b0;
        held_v    = 1'b0;
      end else begin
        if (done || pend_done) check("done_pulse", done, pend_done);
        if (done) done_cnt++;
        pend_done = 1'b0;
        if (stream.out_valid) begin
          if (held_v) check("stall_hold", cur, held);
          if (stream.out_ready) begin
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_beat: got %0h with no beat expected", cur);
            end else begin
              e = exp_q.pop_front();
              check("beat", cur, e);
            end
            xfer_cnt++;
            pend_done = cur.is_k && (cur.idx == k_idx_t'(NUM_ROUNDS - 1));
            held_v    = 1'b0;
          end else begin
            held   = cur;
            held_v = 1'b1;
            if (!cur.is_k && cur.idx == 6'd7) begin
              h7_stall_cnt++;
              check("h7_stall_data", cur.data, 32'h5be0cd19);
            end
          end
        end else begin
          held_v = 1'b0;
        end
      end
    end
  end

  // Downstream ready pattern, updated just after each rising edge.
  initial begin : ready_driver
    stream.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: stream.out_ready = 1'($urandom_range(0, 1));
        2: begin
          if (stream.out_valid && !stream.out_is_k && stream.out_idx == 6'd7 && stall_left > 0) begin
            stream.out_ready = 1'b0;
            stall_left--;
          end else begin
            stream.out_ready = 1'b1;
          end
        end
        default: stream.out_ready = 1'b1;
      endcase
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic push_block(input bit first);
    if (first) begin
      for (int i = 0; i < NUM_H; i++)
        exp_q.push_back('{data: H_TAB[i], idx: k_idx_t'(i), is_k: 1'b0});
    end
    for (int i = 0; i < NUM_ROUNDS; i++)
      exp_q.push_back('{data: K_TAB[i], idx: k_idx_t'(i), is_k: 1'b1});
  endtask

  // Called just after a rising edge with the DUT idle; returns just after
  // the first edge on which out_valid is high.
  task automatic start_block(input bit first);
    check("start_ready_idle", start_ready, 1'b1);
    push_block(first);
    first_block = first;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("prime_no_valid", stream.out_valid, 1'b0);
    @(posedge clk);
    #1;
    check("first_valid", stream.out_valid, 1'b1);
  endtask

  task automatic wait_done(input int budget, output int cycles);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    check("done_seen", done, 1'b1);
    cycles = n;
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input bit first, input int budget, input bit contiguous);
    int x0;
    int cycles;
    int nb;
    nb = first ? NUM_H + NUM_ROUNDS : NUM_ROUNDS;
    x0 = xfer_cnt;
    start_block(first);
    wait_done(budget, cycles);
    if (contiguous) check("cycles_to_done", cycles, nb + 1);
    check("beat_count", xfer_cnt - x0, nb);
    check("queue_drained", exp_q.size(), 0);
    check("idle_after_done", start_ready, 1'b1);
  endtask

  initial begin : stimulus
    int x0;
    int d0;
    int n;
    rst         = 1'b1;
    start       = 1'b0;
    first_block = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_start_ready", start_ready, 1'b1);
    check("rst_out_valid", stream.out_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_out_is_k", stream.out_is_k, 1'b0);
    check("rst_h_addr", h_rom_addr, 3'd0);
    check("rst_k_addr", k_rom_addr, 6'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Full block, no backpressure: 72 contiguous beats.
    ready_mode = 0;
    run_block(1'b1, 200, 1'b1);

    // Chained block: 64 contiguous K beats.
    run_block(1'b0, 200, 1'b1);

    // Random backpressure across a full block.
    ready_mode = 1;
    run_block(1'b1, 1000, 1'b0);

    // Five stall cycles holding H7, then K0 must follow.
    ready_mode   = 2;
    stall_left   = 5;
    h7_stall_cnt = 0;
    run_block(1'b1, 400, 1'b0);
    check("h7_stall_cycles", h7_stall_cnt, 5);
    ready_mode = 0;

    // start during ROUNDS and during the DONE cycle is ignored.
    x0 = xfer_cnt;
    d0 = done_cnt;
    start_block(1'b0);
    repeat (10) @(posedge clk);
    #1;
    start       = 1'b1;
    first_block = 1'b1;
    check("busy_start_ready", start_ready, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (!(stream.out_valid && stream.out_is_k && stream.out_idx == 6'd63) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reached_k63", stream.out_idx, 6'd63);
    @(posedge clk);
    #1;
    check("done_cycle_done", done, 1'b1);
    check("done_cycle_start_ready", start_ready, 1'b0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ignored_start_idle", start_ready, 1'b1);
    check("ignored_start_no_valid", stream.out_valid, 1'b0);
    @(posedge clk);
    #1;
    check("still_idle", start_ready, 1'b1);
    check("busy_beat_count", xfer_cnt - x0, NUM_ROUNDS);
    check("busy_done_count", done_cnt - d0, 1);
    check("busy_queue_drained", exp_q.size(), 0);
    run_block(1'b0, 200, 1'b1);

    // Reset while K30 is on the bus: abandon the block, then replay from H0.
    x0 = xfer_cnt;
    start_block(1'b1);
    n = 0;
    while (xfer_cnt != x0 + NUM_H + 30 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reached_round30", stream.out_idx, 6'd30);
    d0  = done_cnt;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", stream.out_valid, 1'b0);
    check("midrst_start_ready", start_ready, 1'b1);
    check("midrst_done", done, 1'b0);
    exp_q.delete();
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_stays_idle", stream.out_valid, 1'b0);
    run_block(1'b1, 200, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
